// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
//   state_t       : controller state (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/sum width in bits
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder, purely combinational.
//   a, b  : operand bits
//   c_in  : carry in
//   sum   : a ^ b ^ c_in
//   c_out : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller. A single 1-bit full adder is
// time-shared across all operand bits, LSB first, one bit per clock.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   a, b, c_in          : operands and carry-in, sampled on the accept edge
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   sum, c_out          : registered result, held through backpressure
//   busy                : high while an operation is in RUN or DONE
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  // Sum bits arrive LSB first and enter at the MSB, so after WIDTH shifts
  // the first bit has walked down to position 0. Written as shift-then-set
  // so WIDTH=1 needs no special slice.
  always_comb begin
    sum_nxt            = sum_sh >> 1;
    sum_nxt[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= c_in;
            sum_sh   <= '0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt;
          carry  <= fa_cout;
          cnt    <= cnt + CNT_W'(1);
          // Final bit: publish the result straight from this edge's adder
          // output so sum/c_out are valid together with out_valid.
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= sum_nxt;
            c_out     <= fa_cout;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: one WIDTH=8 instance driven by
// directed and random operations, one WIDTH=1 instance driven randomly in
// parallel. Expected results are a+b+c_in computed with plain arithmetic.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic       rst8 = 1'b1;
  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       c8 = 1'b0;
  logic       out_valid8;
  logic       out_ready8 = 1'b0;
  logic [7:0] sum8;
  logic       c_out8;
  logic       busy8;

  // WIDTH=1 instance signals
  logic       rst1 = 1'b1;
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       c1 = 1'b0;
  logic       out_valid1;
  logic       out_ready1 = 1'b0;
  logic [0:0] sum1;
  logic       c_out1;
  logic       busy1;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .c_in(c8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .c_out(c_out8), .busy(busy8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c_in(c1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .c_out(c_out1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a transfer happens on the next rising edge whenever
  // out_valid && out_ready are seen here.
  always @(negedge clk) begin
    if (!rst8 && out_valid8 && out_ready8) begin
      if (q8.size() == 0) chk("w8_unexpected_result", 32'(1), 32'(0));
      else chk("w8_result", 32'({c_out8, sum8}), 32'(q8.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst1 && out_valid1 && out_ready1) begin
      if (q1.size() == 0) chk("w1_unexpected_result", 32'(1), 32'(0));
      else chk("w1_result", 32'({c_out1, sum1}), 32'(q1.pop_front()));
    end
  end

  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int g = 0;
    while (!in_ready8 && g < 64) begin tick(); g++; end
    chk("w8_in_ready_before_send", 32'(in_ready8), 32'(1));
    a8 = av; b8 = bv; c8 = cv; in_valid8 = 1'b1;
    q8.push_back(9'(av) + 9'(bv) + 9'(cv));
    tick();
    in_valid8 = 1'b0;
  endtask

  task automatic wait_valid8(output int n);
    n = 0;
    while (!out_valid8 && n < 64) begin tick(); n++; end
    chk("w8_out_valid_timeout", 32'(out_valid8), 32'(1));
  endtask

  // Full operation with immediate acceptance, plus a check against a
  // hand-computed constant.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input logic [8:0] exp_const, input string name);
    int n;
    out_ready8 = 1'b1;
    send8(av, bv, cv);
    wait_valid8(n);
    chk(name, 32'({c_out8, sum8}), 32'(exp_const));
    tick();
    chk("w8_in_ready_after_xfer", 32'(in_ready8), 32'(1));
    chk("w8_out_valid_after_xfer", 32'(out_valid8), 32'(0));
  endtask

  task automatic run_w8();
    int n, g, stall;
    logic [7:0] av, bv;
    logic       cv;
    logic [8:0] exp;

    // Reset state
    rst8 = 1'b1;
    repeat (3) tick();
    rst8 = 1'b0;
    chk("w8_rst_out_valid", 32'(out_valid8), 32'(0));
    chk("w8_rst_in_ready", 32'(in_ready8), 32'(1));
    chk("w8_rst_sum", 32'(sum8), 32'(0));
    chk("w8_rst_c_out", 32'(c_out8), 32'(0));
    chk("w8_rst_busy", 32'(busy8), 32'(0));

    // First op with latency measurement
    out_ready8 = 1'b1;
    send8(8'h3C, 8'h42, 1'b0);
    wait_valid8(n);
    chk("w8_latency", 32'(n), 32'(8));
    chk("w8_3c_42", 32'({c_out8, sum8}), 32'(9'h07E));
    tick();
    chk("w8_in_ready_after_first", 32'(in_ready8), 32'(1));

    op8(8'hFF, 8'h01, 1'b0, 9'h100, "w8_ff_01");
    op8(8'hA5, 8'h5A, 1'b1, 9'h100, "w8_a5_5a_c1");
    op8(8'h00, 8'h00, 1'b1, 9'h001, "w8_00_00_c1");

    // Backpressure: result held for 5 stalled cycles
    out_ready8 = 1'b0;
    av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
    exp = 9'(av) + 9'(bv) + 9'(cv);
    send8(av, bv, cv);
    wait_valid8(n);
    repeat (5) begin
      tick();
      chk("w8_bp_out_valid", 32'(out_valid8), 32'(1));
      chk("w8_bp_result", 32'({c_out8, sum8}), 32'(exp));
      chk("w8_bp_in_ready", 32'(in_ready8), 32'(0));
    end
    out_ready8 = 1'b1;
    tick();
    chk("w8_bp_release_in_ready", 32'(in_ready8), 32'(1));
    chk("w8_bp_release_out_valid", 32'(out_valid8), 32'(0));

    // Operands changing every cycle while in_valid stays high during RUN
    out_ready8 = 1'b0;
    av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
    a8 = av; b8 = bv; c8 = cv; in_valid8 = 1'b1;
    q8.push_back(9'(av) + 9'(bv) + 9'(cv));
    tick();
    g = 0;
    while (!out_valid8 && g < 64) begin
      chk("w8_run_in_ready", 32'(in_ready8), 32'(0));
      chk("w8_run_busy", 32'(busy8), 32'(1));
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      tick();
      g++;
    end
    chk("w8_hold_timeout", 32'(out_valid8), 32'(1));
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick();

    // Reset during RUN aborts the operation
    send8(8'h80, 8'h80, 1'b0);
    repeat (3) tick();
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    void'(q8.pop_back());
    chk("w8_abort_out_valid", 32'(out_valid8), 32'(0));
    chk("w8_abort_in_ready", 32'(in_ready8), 32'(1));
    chk("w8_abort_busy", 32'(busy8), 32'(0));
    repeat (10) begin
      tick();
      chk("w8_abort_no_result", 32'(out_valid8), 32'(0));
    end
    op8(8'h01, 8'h02, 1'b0, 9'h003, "w8_01_02");

    // Random operations with random result stalls
    for (int i = 0; i < 200; i++) begin
      stall = $urandom_range(0, 3);
      out_ready8 = (stall == 0);
      send8(8'($urandom), 8'($urandom), 1'($urandom));
      wait_valid8(n);
      if (stall > 0) begin
        repeat (stall) tick();
        out_ready8 = 1'b1;
      end
      tick();
    end
    out_ready8 = 1'b0;
  endtask

  task automatic run_w1();
    int g, stall;
    logic av, bv, cv;
    rst1 = 1'b1;
    repeat (3) tick();
    rst1 = 1'b0;
    chk("w1_rst_out_valid", 32'(out_valid1), 32'(0));
    chk("w1_rst_in_ready", 32'(in_ready1), 32'(1));
    for (int i = 0; i < 200; i++) begin
      stall = $urandom_range(0, 2);
      out_ready1 = (stall == 0);
      g = 0;
      while (!in_ready1 && g < 16) begin tick(); g++; end
      chk("w1_in_ready_before_send", 32'(in_ready1), 32'(1));
      av = 1'($urandom); bv = 1'($urandom); cv = 1'($urandom);
      a1 = av; b1 = bv; c1 = cv; in_valid1 = 1'b1;
      q1.push_back(2'(av) + 2'(bv) + 2'(cv));
      tick();
      in_valid1 = 1'b0;
      g = 0;
      while (!out_valid1 && g < 16) begin tick(); g++; end
      chk("w1_latency", 32'(g), 32'(1));
      if (stall > 0) begin
        repeat (stall) tick();
        out_ready1 = 1'b1;
      end
      tick();
    end
    out_ready1 = 1'b0;
  endtask

  initial begin
    fork
      run_w8();
      run_w1();
    join
    repeat (4) tick();
    chk("w8_queue_drained", 32'(q8.size()), 32'(0));
    chk("w1_queue_drained", 32'(q1.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, got %0d vectors expected completion", n_vec);
    $fatal(1);
  end

endmodule
